// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Misalignment rejection is enabled by defining LSU_MISALIGN_CHECK_EN.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_R,
      RESP
   } state_e;

   // Low address bits are snapped down to the natural alignment of the access.
   function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return addr_lo;
         SZ_HALF: return {addr_lo[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SZ_BYTE: return 4'b0001 << offset;
         SZ_HALF: return 4'b0011 << offset;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_BYTE: return {4{wdata[7:0]}};
         SZ_HALF: return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed lane out of a read word and sign- or zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        zero_ext,
   output logic [31:0] data
);

   logic [7:0]  lanes [4];
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lanes[gi] = rdata[8*gi +: 8];
      end
   endgenerate

   assign lane_byte = lanes[offset];
   assign lane_half = offset[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      data = rdata;
      case (size)
         SZ_BYTE: data = {{24{~zero_ext & lane_byte[7]}}, lane_byte};
         SZ_HALF: data = {{16{~zero_ext & lane_half[15]}}, lane_half};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging a core request port to a word memory.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses instead of aligning them.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             we_reg;
   logic             unsigned_reg;
   logic [1:0]       size_reg;
   logic [1:0]       off_reg;
   logic [1:0]       acc_off;
   logic             acc_illegal;
   logic [31:0]      load_data;

   assign acc_off = lane_offset(req_size, req_addr[1:0]);

`ifdef LSU_MISALIGN_CHECK_EN
   assign acc_illegal = (req_size == 2'b11) || is_misaligned(req_size, req_addr[1:0]);
`else
   assign acc_illegal = (req_size == 2'b11);
`endif

   lsu_load_align u_align (
      .rdata    (mem_rdata),
      .size     (size_reg),
      .offset   (off_reg),
      .zero_ext (unsigned_reg),
      .data     (load_data)
   );

   // All outputs are registered; each transition sets what the next state presents.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         we_reg       <= 1'b0;
         unsigned_reg <= 1'b0;
         size_reg     <= 2'b00;
         off_reg      <= 2'b00;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_err     <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_be       <= 4'b0000;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready    <= 1'b0;
                  we_reg       <= req_we;
                  size_reg     <= req_size;
                  unsigned_reg <= req_unsigned;
                  off_reg      <= acc_off;
                  mem_addr     <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_wdata    <= store_lanes(req_size, req_wdata);
                  if (acc_illegal) begin
                     state_reg  <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state_reg <= ISSUE;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_be    <= byte_enables(req_size, acc_off);
                  end
               end
            end
            ISSUE: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  mem_be  <= 4'b0000;
                  cnt_reg <= '0;
                  if (we_reg) begin
                     state_reg  <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_rdata <= '0;
                  end else begin
                     state_reg <= WAIT_R;
                  end
               end
            end
            WAIT_R: begin
               if (mem_rvalid) begin
                  state_reg  <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_data;
               end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                  state_reg  <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            RESP: begin
               state_reg  <= IDLE;
               req_ready  <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: begin
               state_reg <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a behavioural access model.
module tb_load_store_unit;

   localparam int TMO = 4;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_gnt;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      bit          ready_before;
      bit          req_seen;
      bit          stable;
      bit          got;
      bit          err;
      bit          we;
      bit          valid_after;
      bit          ready_after;
      int          issue_cycles;
      int          wait_cycles;
      int          latency;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  be;
   } obs_t;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int nbytes_of(input logic [1:0] size);
      return 1 << size;
   endfunction

   function automatic bit exp_illegal(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'b11) return 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
      return (int'(addr % 4) % nbytes_of(size)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int exp_off(input logic [1:0] size, input logic [31:0] addr);
      int n = nbytes_of(size);
      return (int'(addr % 4) / n) * n;
   endfunction

   function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [31:0] addr);
      int n = nbytes_of(size);
      return 4'(((1 << n) - 1) << exp_off(size, addr));
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] wdata);
      longint m = longint'(1) << (8 * nbytes_of(size));
      return 32'((longint'(wdata) % m) * (longint'(64'hFFFF_FFFF) / (m - 1)));
   endfunction

   function automatic logic [31:0] exp_load(input logic [1:0] size, input bit uns,
                                            input logic [31:0] addr, input logic [31:0] word);
      int     nb   = 8 * nbytes_of(size);
      longint lane = (longint'(word) >> (8 * exp_off(size, addr))) % (longint'(1) << nb);
      if (!uns && lane >= (longint'(1) << (nb - 1))) lane = lane - (longint'(1) << nb);
      return 32'(lane);
   endfunction

   // ---------------- stimulus driver (observes only, no checking) ----------------
   task automatic drive_txn(input bit we, input logic [1:0] size, input bit uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int gnt_delay, input int rv_delay,
                            input logic [31:0] rword, input bit noise, output obs_t o);
      int cyc;
      int wait_cyc;
      o = '0;
      o.stable = 1'b1;
      @(negedge clk);
      o.ready_before = req_ready;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      wait_cyc = -1;
      while (cyc <= 64) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (resp_valid) begin
            o.got = 1'b1; o.latency = cyc; o.rdata = resp_rdata; o.err = resp_err;
            break;
         end
         if (mem_req) begin
            if (!o.req_seen) begin
               o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
            end else if (o.addr !== mem_addr || o.be !== mem_be || o.wdata !== mem_wdata || o.we !== mem_we) begin
               o.stable = 1'b0;
            end
            if (req_ready !== 1'b0) o.stable = 1'b0;
            o.req_seen = 1'b1;
            o.issue_cycles++;
            mem_rvalid = noise & 1'($urandom_range(0, 1));
            if (o.issue_cycles == gnt_delay + 1) begin
               mem_gnt = 1'b1;
               wait_cyc = 0;
            end
         end else if (wait_cyc >= 0) begin
            if (rv_delay >= 0 && wait_cyc == rv_delay) begin
               mem_rvalid = 1'b1; mem_rdata = rword;
            end
            wait_cyc++;
         end
         @(negedge clk);
         cyc++;
      end
      o.wait_cycles = wait_cyc;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      o.valid_after = resp_valid;
      o.ready_after = req_ready;
      $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h gnt_dly=%0d rv_dly=%0d -> lat=%0d err=%0d rdata=%h be=%b",
               we, size, uns, addr, wdata, gnt_delay, rv_delay, o.latency, o.err, o.rdata, o.be);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [104:0] outs;
      rst = 1'b1;
      @(negedge clk);
      outs = {req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata};
      vectors++;
      if (outs !== {1'b1, 104'd0}) begin
         miscompares++;
         $display("FAIL reset_outputs got %h exp %h", outs, {1'b1, 104'd0});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release ready=%b mem_req=%b exp ready=1 mem_req=0", req_ready, mem_req);
      end
   endtask

   task automatic test_byte_store();
      obs_t o;
      drive_txn(1'b1, 2'b00, 1'b0, 32'h1003, 32'h0000_00AB, 0, 0, 32'h0, 1'b0, o);
      vectors++;
      if ({o.addr, o.be, o.wdata, o.we} !== {32'h1000, 4'b1000, 32'hABAB_ABAB, 1'b1}) begin
         miscompares++;
         $display("FAIL byte_store_mem addr=%h be=%b wdata=%h we=%b exp 00001000 1000 ababab ab 1",
                  o.addr, o.be, o.wdata, o.we);
      end
      vectors++;
      if (!o.got || o.latency !== 2 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL byte_store_resp got=%b lat=%0d err=%b rdata=%h exp 1 2 0 0", o.got, o.latency, o.err, o.rdata);
      end
      vectors++;
      if (o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
         miscompares++;
         $display("FAIL byte_store_pulse valid_after=%b ready_after=%b exp 0 1", o.valid_after, o.ready_after);
      end
   endtask

   task automatic test_half_load();
      obs_t o;
      drive_txn(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 0, 0, 32'h8001_0000, 1'b0, o);
      vectors++;
      if (!o.got || o.latency !== 3 || o.rdata !== 32'hFFFF_8001 || o.err !== 1'b0) begin
         miscompares++;
         $display("FAIL half_load_signed lat=%0d rdata=%h err=%b exp 3 ffff8001 0", o.latency, o.rdata, o.err);
      end
      vectors++;
      if (o.be !== 4'b1100 || o.addr !== 32'h2000 || o.we !== 1'b0) begin
         miscompares++;
         $display("FAIL half_load_mem be=%b addr=%h we=%b exp 1100 00002000 0", o.be, o.addr, o.we);
      end
      drive_txn(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 0, 0, 32'h8001_0000, 1'b0, o);
      vectors++;
      if (!o.got || o.rdata !== 32'h0000_8001) begin
         miscompares++;
         $display("FAIL half_load_unsigned rdata=%h exp 00008001", o.rdata);
      end
   endtask

   task automatic test_grant_stall();
      obs_t o;
      drive_txn(1'b1, 2'b10, 1'b0, 32'h0000_5A5C, 32'h1234_5678, 5, 0, 32'h0, 1'b1, o);
      vectors++;
      if (o.issue_cycles !== 6 || o.stable !== 1'b1) begin
         miscompares++;
         $display("FAIL grant_stall issue_cycles=%0d stable=%b exp 6 1", o.issue_cycles, o.stable);
      end
      vectors++;
      if (!o.got || o.latency !== 7 || o.wdata !== 32'h1234_5678 || o.addr !== 32'h5A5C) begin
         miscompares++;
         $display("FAIL grant_stall_resp lat=%0d wdata=%h addr=%h exp 7 12345678 00005a5c", o.latency, o.wdata, o.addr);
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      drive_txn(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0, -1, 32'h0, 1'b0, o);
      vectors++;
      if (!o.got || o.err !== 1'b1 || o.rdata !== 32'h0 || o.wait_cycles !== TMO || o.latency !== TMO + 2) begin
         miscompares++;
         $display("FAIL timeout got=%b err=%b rdata=%h wait=%0d lat=%0d exp 1 1 0 %0d %0d",
                  o.got, o.err, o.rdata, o.wait_cycles, o.latency, TMO, TMO + 2);
      end
   endtask

   task automatic test_misalign();
      obs_t o;
      drive_txn(1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0, o);
`ifdef LSU_MISALIGN_CHECK_EN
      vectors++;
      if (!o.got || o.err !== 1'b1 || o.req_seen !== 1'b0 || o.rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL misalign_word err=%b req_seen=%b rdata=%h exp 1 0 0", o.err, o.req_seen, o.rdata);
      end
`else
      vectors++;
      if (!o.got || o.err !== 1'b0 || o.addr !== 32'h3000 || o.be !== 4'b1111 || o.rdata !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL misalign_word err=%b addr=%h be=%b rdata=%h exp 0 00003000 1111 cafef00d",
                  o.err, o.addr, o.be, o.rdata);
      end
`endif
   endtask

   task automatic test_illegal_size();
      obs_t o;
      drive_txn(1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 0, 0, 32'h0, 1'b0, o);
      vectors++;
      if (!o.got || o.err !== 1'b1 || o.req_seen !== 1'b0 || o.latency !== 1 || o.rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL illegal_size err=%b req_seen=%b lat=%0d rdata=%h exp 1 0 1 0", o.err, o.req_seen, o.latency, o.rdata);
      end
   endtask

   task automatic test_reset_in_wait();
      int spurious = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h4000;
      @(negedge clk);
      req_valid = 1'b0;
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      vectors++;
      if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL wait_r_entry mem_req=%b resp_valid=%b ready=%b exp 0 0 0", mem_req, resp_valid, req_ready);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_wait_ready got %b exp 1", req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1'b1; mem_rdata = $urandom;
         @(negedge clk);
         if (resp_valid !== 1'b0 || mem_req !== 1'b0) spurious++;
      end
      mem_rvalid = 1'b0;
      vectors++;
      if (spurious !== 0 || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL late_rvalid spurious_cycles=%0d ready=%b exp 0 1", spurious, req_ready);
      end
      $display("txn reset-in-wait then late rvalid: spurious=%0d", spurious);
   endtask

   task automatic test_random();
      obs_t o;
      for (int t = 0; t < 40; t++) begin
         bit          we   = 1'($urandom_range(0, 1));
         logic [1:0]  size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         bit          uns  = 1'($urandom_range(0, 1));
         logic [31:0] addr = $urandom;
         logic [31:0] wd   = $urandom;
         logic [31:0] rw   = $urandom;
         int          gd   = $urandom_range(0, 3);
         int          rvd  = $urandom_range(0, 5);
         bit          ill;
         bit          tmo;
         int          lat;
         logic [31:0] erd;
         if (rvd == 5) rvd = -1;
         drive_txn(we, size, uns, addr, wd, gd, rvd, rw, 1'b1, o);
         ill = exp_illegal(size, addr);
         tmo = !ill && !we && (rvd < 0 || rvd >= TMO);
         if (ill) begin
            lat = 1; erd = 32'h0;
         end else if (we) begin
            lat = gd + 2; erd = 32'h0;
         end else if (tmo) begin
            lat = gd + 2 + TMO; erd = 32'h0;
         end else begin
            lat = gd + 3 + rvd; erd = exp_load(size, uns, addr, rw);
         end
         vectors++;
         if (!o.got || o.latency !== lat || o.err !== (ill || tmo) || o.rdata !== erd) begin
            miscompares++;
            $display("FAIL rand_resp[%0d] got=%b lat=%0d err=%b rdata=%h exp lat=%0d err=%b rdata=%h",
                     t, o.got, o.latency, o.err, o.rdata, lat, ill || tmo, erd);
         end
         vectors++;
         if (ill) begin
            if (o.req_seen !== 1'b0) begin
               miscompares++;
               $display("FAIL rand_skip[%0d] mem_req seen for rejected access", t);
            end
         end else if (o.addr !== {addr[31:2], 2'b00} || o.be !== exp_be(size, addr) || o.we !== we ||
                      (we && o.wdata !== exp_wdata(size, wd)) || o.stable !== 1'b1 || o.issue_cycles !== gd + 1) begin
            miscompares++;
            $display("FAIL rand_mem[%0d] addr=%h be=%b we=%b wdata=%h stable=%b issue=%0d exp addr=%h be=%b we=%b wdata=%h stable=1 issue=%0d",
                     t, o.addr, o.be, o.we, o.wdata, o.stable, o.issue_cycles,
                     {addr[31:2], 2'b00}, exp_be(size, addr), we, exp_wdata(size, wd), gd + 1);
         end
         vectors++;
         if (o.ready_before !== 1'b1 || o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
            miscompares++;
            $display("FAIL rand_handshake[%0d] ready_before=%b valid_after=%b ready_after=%b exp 1 0 1",
                     t, o.ready_before, o.valid_after, o.ready_after);
         end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      test_reset();
      test_byte_store();
      test_half_load();
      test_grant_stall();
      test_timeout();
      test_misalign();
      test_illegal_size();
      test_reset_in_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
